// File: rtl/demux_stream_1ton_if.sv
// Stream bundle between one ingress producer and the per-channel consumers of demux_stream_1ton.
// master: drives the ingress beat and the per-channel out_ready. slave: the demux side.
interface demux_stream_1ton_if #(
    parameter int DW   = 8,
    parameter int NCH  = 4,
    parameter int SELW = 2
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [SELW-1:0]   in_sel;
    logic              in_last;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    out_ready;
    logic [NCH*DW-1:0] out_data;
    logic [NCH-1:0]    out_last;

    modport master (
        output in_valid, in_data, in_sel, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/demux_stream_1ton.sv
// 1-to-NCH packet-locked stream demux, one output register per channel; DEMUX_STREAM_CNT_EN adds beat/drop counters.
// Latency: an accepted beat is visible on its channel one cycle later.
// Backpressure: in_ready follows only the destination channel register; bad-select/dropped beats are always accepted.
module demux_stream_1ton #(
    parameter int DW   = 8,
    parameter int NCH  = 4,
    parameter int SELW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    demux_stream_1ton_if.slave s,
    output logic               err_sel
`ifdef DEMUX_STREAM_CNT_EN
    ,
    output logic [NCH*16-1:0]  beat_cnt,
    output logic [15:0]        drop_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, LOCK, DROP} state_t;

    state_t          state;
    logic [SELW-1:0] sel_q;
    logic [SELW-1:0] act_sel;
    logic            dst_ok;
    logic            dst_free;
    logic            acc;
    logic [NCH-1:0]  load;
    logic [NCH-1:0]  vld;

    always_comb begin
        act_sel  = (state == LOCK) ? sel_q : s.in_sel;
        dst_ok   = (state != DROP) && (int'(act_sel) < NCH);
        dst_free = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (act_sel == SELW'(k)) dst_free = ~vld[k] | s.out_ready[k];
        end
    end

    assign s.in_ready = dst_ok ? dst_free : 1'b1;
    assign acc        = s.in_valid & s.in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < NCH; k++) begin
            load[k] = acc & dst_ok & (act_sel == SELW'(k));
        end
    end

    assign s.out_valid = vld;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic          vld_r;
        logic          last_r;
        logic [DW-1:0] dat_r;

        // A load wins over a drain, so a back-to-back beat replaces the old one without a bubble.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r  <= 1'b0;
                last_r <= 1'b0;
                dat_r  <= '0;
            end else if (load[k]) begin
                vld_r  <= 1'b1;
                last_r <= s.in_last;
                dat_r  <= s.in_data;
            end else if (s.out_ready[k]) begin
                vld_r  <= 1'b0;
            end
        end

        assign vld[k]                 = vld_r;
        assign s.out_last[k]          = last_r;
        assign s.out_data[k*DW +: DW] = dat_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_q   <= '0;
            err_sel <= 1'b0;
        end else begin
            err_sel <= 1'b0;
            if (acc) begin
                case (state)
                    IDLE: begin
                        if (dst_ok) begin
                            if (!s.in_last) begin
                                sel_q <= s.in_sel;
                                state <= LOCK;
                            end
                        end else begin
                            err_sel <= 1'b1;
                            if (!s.in_last) state <= DROP;
                        end
                    end
                    LOCK, DROP: begin
                        if (s.in_last) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef DEMUX_STREAM_CNT_EN
    logic discard;
    assign discard = acc & ~dst_ok;

    for (genvar k = 0; k < NCH; k++) begin : g_cnt
        logic [15:0] cnt_r;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                          cnt_r <= '0;
            else if (vld[k] & s.out_ready[k])   cnt_r <= cnt_r + 16'd1;
        end
        assign beat_cnt[k*16 +: 16] = cnt_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       drop_cnt <= '0;
        else if (discard) drop_cnt <= drop_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Directed bench for demux_stream_1ton: a 4-channel instance for routing/locking/backpressure/reset
// and a 3-channel instance for the bad-select drop path; counter wrap runs when DEMUX_STREAM_CNT_EN is set.
module tb_demux_stream_1ton;

    logic clk;
    logic rst_n;
    logic err_a, err_b;
    int   checks = 0;
    int   errors = 0;

    demux_stream_1ton_if #(.DW(8), .NCH(4), .SELW(2)) a ();
    demux_stream_1ton_if #(.DW(8), .NCH(3), .SELW(2)) b ();

`ifdef DEMUX_STREAM_CNT_EN
    logic [63:0] beat_cnt_a;
    logic [15:0] drop_cnt_a;
    logic [47:0] beat_cnt_b;
    logic [15:0] drop_cnt_b;
`endif

    demux_stream_1ton #(.DW(8), .NCH(4), .SELW(2)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (a),
        .err_sel  (err_a)
`ifdef DEMUX_STREAM_CNT_EN
        ,
        .beat_cnt (beat_cnt_a),
        .drop_cnt (drop_cnt_a)
`endif
    );

    demux_stream_1ton #(.DW(8), .NCH(3), .SELW(2)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (b),
        .err_sel  (err_b)
`ifdef DEMUX_STREAM_CNT_EN
        ,
        .beat_cnt (beat_cnt_b),
        .drop_cnt (drop_cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [7:0] d, input logic [1:0] sel, input logic last);
        a.in_valid = v;
        a.in_data  = d;
        a.in_sel   = sel;
        a.in_last  = last;
    endtask

    task automatic drive_b(input logic v, input logic [7:0] d, input logic [1:0] sel, input logic last);
        b.in_valid = v;
        b.in_data  = d;
        b.in_sel   = sel;
        b.in_last  = last;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_a(1'b0, 8'h00, 2'd0, 1'b0);
        drive_b(1'b0, 8'h00, 2'd0, 1'b0);
        a.out_ready = 4'hF;
        b.out_ready = 3'h7;
        #12;
        check("rst_out_valid", a.out_valid, 4'h0);
        check("rst_out_last",  a.out_last,  4'h0);
        check("rst_out_data",  a.out_data,  32'h0);
        check("rst_err_sel",   err_a,       1'b0);
        check("rst_b_valid",   b.out_valid, 3'h0);
        rst_n = 1'b1;
        tick();

        // single-beat packets to every channel
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 8'hA1 + 8'(i), 2'(i), 1'b1);
            #1;
            check("single_in_ready", a.in_ready, 1'b1);
            tick();
            check("single_valid", a.out_valid, 32'(1 << i));
            check("single_data",  a.out_data[i*8 +: 8], 8'hA1 + 8'(i));
            check("single_last",  a.out_last[i], 1'b1);
        end
        drive_a(1'b0, 8'h00, 2'd0, 1'b0);
        tick();
        check("single_drained", a.out_valid, 4'h0);

        // 3-beat packet locked to channel 2 despite in_sel changing
        drive_a(1'b1, 8'h10, 2'd2, 1'b0);
        tick();
        check("lock_b0_valid", a.out_valid, 4'b0100);
        check("lock_b0_data",  a.out_data[23:16], 8'h10);
        check("lock_b0_last",  a.out_last[2], 1'b0);
        drive_a(1'b1, 8'h11, 2'd1, 1'b0);
        tick();
        check("lock_b1_valid", a.out_valid, 4'b0100);
        check("lock_b1_data",  a.out_data[23:16], 8'h11);
        drive_a(1'b1, 8'h12, 2'd1, 1'b1);
        tick();
        check("lock_b2_valid", a.out_valid, 4'b0100);
        check("lock_b2_data",  a.out_data[23:16], 8'h12);
        check("lock_b2_last",  a.out_last[2], 1'b1);
        drive_a(1'b1, 8'h55, 2'd1, 1'b1);
        tick();
        check("unlock_valid", a.out_valid, 4'b0010);
        check("unlock_data",  a.out_data[15:8], 8'h55);
        drive_a(1'b0, 8'h00, 2'd0, 1'b0);
        tick();

        // backpressure on channel 1 must not block channel 0
        a.out_ready = 4'b1101;
        drive_a(1'b1, 8'h20, 2'd1, 1'b1);
        tick();
        check("bp_first_valid", a.out_valid, 4'b0010);
        check("bp_first_data",  a.out_data[15:8], 8'h20);
        drive_a(1'b1, 8'h21, 2'd1, 1'b1);
        #1;
        check("bp_in_ready_low", a.in_ready, 1'b0);
        tick();
        check("bp_held_data",  a.out_data[15:8], 8'h20);
        check("bp_held_valid", a.out_valid, 4'b0010);
        drive_a(1'b1, 8'h30, 2'd0, 1'b1);
        #1;
        check("bp_ch0_ready", a.in_ready, 1'b1);
        tick();
        check("bp_ch0_valid", a.out_valid, 4'b0011);
        check("bp_ch0_data",  a.out_data[7:0], 8'h30);
        check("bp_ch1_still", a.out_data[15:8], 8'h20);
        drive_a(1'b1, 8'h21, 2'd1, 1'b1);
        #1;
        check("bp_still_low", a.in_ready, 1'b0);
        a.out_ready = 4'hF;
        #1;
        check("bp_released", a.in_ready, 1'b1);
        tick();
        check("bp_second_valid", a.out_valid, 4'b0010);
        check("bp_second_data",  a.out_data[15:8], 8'h21);
        drive_a(1'b0, 8'h00, 2'd0, 1'b0);
        tick();
        check("bp_drained", a.out_valid, 4'h0);

        // bad select on the 3-channel instance: whole packet dropped, one error pulse
        drive_b(1'b1, 8'h40, 2'd3, 1'b0);
        #1;
        check("drop_b0_ready", b.in_ready, 1'b1);
        tick();
        check("drop_err_pulse", err_b, 1'b1);
        check("drop_b0_valid",  b.out_valid, 3'h0);
        drive_b(1'b1, 8'h41, 2'd0, 1'b1);
        #1;
        check("drop_b1_ready", b.in_ready, 1'b1);
        tick();
        check("drop_err_once", err_b, 1'b0);
        check("drop_b1_valid", b.out_valid, 3'h0);
        drive_b(1'b1, 8'h42, 2'd0, 1'b1);
        tick();
        check("drop_idle_valid", b.out_valid, 3'b001);
        check("drop_idle_data",  b.out_data[7:0], 8'h42);
        check("drop_idle_err",   err_b, 1'b0);
        drive_b(1'b0, 8'h00, 2'd0, 1'b0);
`ifdef DEMUX_STREAM_CNT_EN
        check("drop_cnt", drop_cnt_b, 16'd2);
`endif
        tick();

        // reset mid-packet while locked to channel 2 with a beat parked there
        a.out_ready = 4'b1011;
        drive_a(1'b1, 8'h50, 2'd2, 1'b0);
        tick();
        check("rstmid_pre_valid", a.out_valid, 4'b0100);
        drive_a(1'b0, 8'h00, 2'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", a.out_valid, 4'h0);
        check("rstmid_data",  a.out_data, 32'h0);
        #1;
        rst_n = 1'b1;
        a.out_ready = 4'hF;
        drive_a(1'b1, 8'h60, 2'd0, 1'b1);
        tick();
        check("rstmid_next_valid", a.out_valid, 4'b0001);
        check("rstmid_next_data",  a.out_data[7:0], 8'h60);
        drive_a(1'b0, 8'h00, 2'd0, 1'b0);
        tick();

`ifdef DEMUX_STREAM_CNT_EN
        rst_n = 1'b0;
        #1;
        check("cnt_rst", beat_cnt_a[15:0], 16'd0);
        rst_n = 1'b1;
        drive_a(1'b1, 8'h77, 2'd0, 1'b1);
        for (int i = 0; i < 65537; i++) tick();
        drive_a(1'b0, 8'h00, 2'd0, 1'b0);
        tick();
        check("cnt_wrap", beat_cnt_a[15:0], 16'd1);
        check("cnt_ch1",  beat_cnt_a[31:16], 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
